// File: rtl/percept_pkg.sv
// Shared definitions for the perceptron driver and the perceptron bench:
// default operand width, command encodings and driver FSM state encodings.
package percept_pkg;

  localparam int SIZE_DEF = 32;

  typedef enum logic [1:0] {
    OP_MAC   = 2'b00,
    OP_FLUSH = 2'b01,
    OP_READ  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    MAC    = 3'd2,
    RDSH   = 3'd3,
    RDLAST = 3'd4,
    RSP    = 3'd5
  } state_e;

  // Sequence counter width: enough to count the longest phase (4*size cycles).
  function automatic int cnt_w(input int size);
    return $clog2(4 * size + 1);
  endfunction

endpackage

// File: rtl/percept_driver_if.sv
// Command/response handshake bundle between a host and the perceptron driver.
interface percept_driver_if
  import percept_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [SIZE-1:0]       cmd_a;
  logic [SIZE-1:0]       cmd_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [4*SIZE-1:0]     rsp_data;

  // Host side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  // Driver side: accepts commands, produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/percept_deser.sv
// Readback deserialiser: the perceptron answers each shift_out strobe with a
// registered bit one cycle later, so capture is enabled by a one-cycle delayed
// copy of shift_out and bits are shifted in MSB-first.
module percept_deser #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic         smp_src,
  input  logic         bit_in,
  output logic [W-1:0] data
);

  logic         smp_en_q, smp_en_d;
  logic [W-1:0] data_q, data_d;

  // Delay the sample request and shift the returned bit into the capture word.
  always_comb begin
    smp_en_d = smp_src;
    data_d   = data_q;
    if (smp_en_q) begin
      data_d = {data_q[W-2:0], bit_in};
    end
  end

  // Capture state, cleared asynchronously with the driver.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      smp_en_q <= 1'b0;
      data_q   <= '0;
    end else begin
      smp_en_q <= smp_en_d;
      data_q   <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/percept_driver.sv
// Serial driver for a bit-serial perceptron MAC unit. Turns MAC/FLUSH/READ/NOP
// commands into shift_in / mul_and_acc / shift_out strobe sequences and
// collects the serial accumulator readback into a 4*SIZE-bit response.
module percept_driver
  import percept_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic             clk,
  input  logic             nRst,
  percept_driver_if.slave  bus,
  output logic             shift_in,
  output logic             shift_out,
  output logic             mul_and_acc,
  output logic             data_in,
  input  logic             pe_data_out
);

  localparam int OPW = 2 * SIZE;
  localparam int RW  = 4 * SIZE;
  localparam int CW  = cnt_w(SIZE);

  localparam logic [CW-1:0] SH_LAST = CW'(OPW - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RW - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OPW-1:0]   opsr_q, opsr_d;
  logic             shift_in_q, shift_in_d;
  logic             shift_out_q, shift_out_d;
  logic             mac_q, mac_d;
  logic             data_in_q, data_in_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]    rsp_data_w;

  // Next-state and next-strobe logic; strobes default low so at most one is set.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opsr_d      = opsr_q;
    rsp_valid_d = rsp_valid_q;
    shift_in_d  = 1'b0;
    shift_out_d = 1'b0;
    mac_d       = 1'b0;
    data_in_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (op_e'(bus.cmd_op))
            OP_MAC: begin
              // First bit leaves on acceptance; the register holds the rest.
              state_d    = SHIFT;
              cnt_d      = '0;
              shift_in_d = 1'b1;
              data_in_d  = bus.cmd_a[SIZE-1];
              opsr_d     = {bus.cmd_a, bus.cmd_b} << 1;
            end
            OP_FLUSH: begin
              state_d    = SHIFT;
              cnt_d      = '0;
              shift_in_d = 1'b1;
              data_in_d  = 1'b0;
              opsr_d     = '0;
            end
            OP_READ: begin
              state_d     = RDSH;
              cnt_d       = '0;
              shift_out_d = 1'b1;
            end
            default: begin
              // NOP: accepted, nothing issued.
            end
          endcase
        end
      end
      SHIFT: begin
        if (cnt_q == SH_LAST) begin
          state_d = MAC;
          cnt_d   = '0;
          mac_d   = 1'b1;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          shift_in_d = 1'b1;
          data_in_d  = opsr_q[OPW-1];
          opsr_d     = opsr_q << 1;
        end
      end
      MAC: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      RDSH: begin
        if (cnt_q == RD_LAST) begin
          state_d = RDLAST;
          cnt_d   = '0;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          shift_out_d = 1'b1;
        end
      end
      RDLAST: begin
        // Last readback bit is captured this cycle; response is ready next.
        state_d     = RSP;
        cnt_d       = '0;
        rsp_valid_d = 1'b1;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          cnt_d       = '0;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, counter, operand shifter and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opsr_q      <= '0;
      shift_in_q  <= 1'b0;
      shift_out_q <= 1'b0;
      mac_q       <= 1'b0;
      data_in_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opsr_q      <= opsr_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      mac_q       <= mac_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  percept_deser #(
    .W(RW)
  ) u_deser (
    .clk     (clk),
    .nRst    (nRst),
    .smp_src (shift_out_q),
    .bit_in  (pe_data_out),
    .data    (rsp_data_w)
  );

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_w;
  assign shift_in      = shift_in_q;
  assign shift_out     = shift_out_q;
  assign mul_and_acc   = mac_q;
  assign data_in       = data_in_q;

endmodule

// File: tb/tb_percept_driver.sv
// Directed bench for percept_driver with a behavioural bit-serial perceptron.
module tb_percept_driver;
  import percept_pkg::*;

  localparam int SIZE = 32;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic shift_in, shift_out, mul_and_acc, data_in, pe_data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int multi_err = 0;

  percept_driver_if #(.SIZE(SIZE)) bus ();

  percept_driver #(.SIZE(SIZE)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .bus         (bus),
    .shift_in    (shift_in),
    .shift_out   (shift_out),
    .mul_and_acc (mul_and_acc),
    .data_in     (data_in),
    .pe_data_out (pe_data_out)
  );

  always #5 clk = ~clk;

  // Perceptron: shifts operands in, product pipelined one MAC behind,
  // destructive MSB-first readback with a registered output bit.
  logic [63:0]  pe_sr;
  logic [63:0]  pe_pend;
  logic [127:0] pe_acc;
  logic         pe_q;
  assign pe_data_out = pe_q;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pe_sr   <= '0;
      pe_pend <= '0;
      pe_acc  <= '0;
      pe_q    <= 1'b0;
    end else begin
      if (shift_in) pe_sr <= {pe_sr[62:0], data_in};
      if (mul_and_acc) begin
        pe_acc  <= pe_acc + {64'd0, pe_pend};
        pe_pend <= 64'(pe_sr[63:32]) * 64'(pe_sr[31:0]);
      end
      if (shift_out) begin
        pe_q   <= pe_acc[127];
        pe_acc <= pe_acc << 1;
      end
    end
  end

  // Strobe exclusivity monitor.
  always @(negedge clk) begin
    if (nRst && ($countones({shift_in, shift_out, mul_and_acc}) > 1)) multi_err++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (bus.cmd_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("timeout_cmd_ready", 128'd0, 128'd1);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    wait_ready();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int k = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("timeout_rsp_valid", 128'd0, 128'd1);
  endtask

  task automatic read_acc(output logic [127:0] d);
    send_cmd(OP_READ, 32'd0, 32'd0);
    wait_rsp();
    d = bus.rsp_data;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] rd;
    logic [127:0] held;
    logic [63:0]  seq;
    int sin_cnt, sin_first, sin_last, mac_cnt, mac_at, so_cnt, bad;
    logic rdy65, rdy66;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b11;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state.
    #2;
    chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    chk("rst_rsp_data", bus.rsp_data, 128'd0);
    chk("rst_strobes", 128'({shift_in, shift_out, mul_and_acc, data_in}), 128'd0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;

    // MAC 3,5 with cycle-accurate strobe timing.
    send_cmd(OP_MAC, 32'd3, 32'd5);
    sin_cnt = 0; sin_first = 0; sin_last = 0; mac_cnt = 0; mac_at = 0; so_cnt = 0;
    seq = '0; rdy65 = 1'b1; rdy66 = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      if (shift_in) begin
        sin_cnt++;
        if (sin_first == 0) sin_first = c;
        sin_last = c;
      end
      if (c <= 64) seq[64-c] = data_in;
      if (mul_and_acc) begin
        mac_cnt++;
        mac_at = c;
      end
      if (shift_out) so_cnt++;
      if (c == 65) rdy65 = bus.cmd_ready;
      if (c == 66) rdy66 = bus.cmd_ready;
    end
    chk("mac_shift_in_count", 128'(sin_cnt), 128'd64);
    chk("mac_shift_first", 128'(sin_first), 128'd1);
    chk("mac_shift_last", 128'(sin_last), 128'd64);
    chk("mac_strobe_count", 128'(mac_cnt), 128'd1);
    chk("mac_strobe_cycle", 128'(mac_at), 128'd65);
    chk("mac_no_shift_out", 128'(so_cnt), 128'd0);
    chk("mac_data_in_seq", 128'(seq), {64'd0, 32'd3, 32'd5});
    chk("mac_ready_65", 128'(rdy65), 128'd0);
    chk("mac_ready_66", 128'(rdy66), 128'd1);

    // FLUSH then destructive reads.
    send_cmd(OP_FLUSH, 32'hDEAD_BEEF, 32'h1234_5678);
    read_acc(rd);
    chk("read_3x5", rd, 128'd15);
    read_acc(rd);
    chk("read_destructive", rd, 128'd0);

    // Full-scale operands, two MACs and a flush.
    send_cmd(OP_MAC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_cmd(OP_MAC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_cmd(OP_FLUSH, 32'd0, 32'd0);
    read_acc(rd);
    chk("read_max_x2", rd, 128'h1_FFFF_FFFC_0000_0002);

    // Response held under back-pressure.
    send_cmd(OP_MAC, 32'd6, 32'd7);
    send_cmd(OP_FLUSH, 32'd0, 32'd0);
    send_cmd(OP_READ, 32'd0, 32'd0);
    wait_rsp();
    held = bus.rsp_data;
    chk("hold_value", held, 128'd42);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_data !== held) bad++;
      if (bus.cmd_ready !== 1'b0) bad++;
      if (bus.rsp_valid !== 1'b1) bad++;
      if ({shift_in, shift_out, mul_and_acc} !== 3'b000) bad++;
    end
    chk("hold_stable", 128'(bad), 128'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold_idle_after", 128'({bus.cmd_ready, bus.rsp_valid}), 128'b10);

    // Reset in the middle of a SHIFT.
    send_cmd(OP_MAC, 32'd9, 32'd9);
    repeat (20) @(negedge clk);
    chk("pre_rst_shifting", 128'(shift_in), 128'd1);
    #1 nRst = 1'b0;
    #1;
    chk("midrst_strobes", 128'({shift_in, shift_out, mul_and_acc, data_in}), 128'd0);
    chk("midrst_ready", 128'(bus.cmd_ready), 128'd1);
    @(negedge clk);
    #2 nRst = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({shift_in, shift_out, mul_and_acc} !== 3'b000) bad++;
    end
    chk("postrst_quiet", 128'(bad), 128'd0);

    // MAC 2,7 with command-bus noise that must be ignored while busy.
    send_cmd(OP_MAC, 32'd2, 32'd7);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_READ;
    bus.cmd_a     = 32'hFFFF_0000;
    bus.cmd_b     = 32'h0000_FFFF;
    repeat (10) @(negedge clk);
    bus.cmd_valid = 1'b0;
    send_cmd(OP_FLUSH, 32'd0, 32'd0);
    read_acc(rd);
    chk("read_after_reset", rd, 128'd14);

    // NOP.
    send_cmd(OP_NOP, 32'd1, 32'd1);
    @(negedge clk);
    chk("nop_ready", 128'(bus.cmd_ready), 128'd1);
    chk("nop_strobes", 128'({shift_in, shift_out, mul_and_acc}), 128'd0);

    chk("no_double_strobe", 128'(multi_err), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/percept_driver.md
PERCEPT_DRIVER -- requirements
Module: percept_driver

Interface
REQ-001 SHALL have parameter SIZE, default 32: operand width; result width is 4*SIZE.
REQ-002 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port nRst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-006 SHALL have port cmd_op  in  2  00 MAC, 01 FLUSH, 10 READ, 11 NOP.
REQ-007 SHALL have port cmd_a  in  SIZE  first operand, MAC only.
REQ-008 SHALL have port cmd_b  in  SIZE  second operand, MAC only.
REQ-009 SHALL have port rsp_valid  out  1  result available.
REQ-010 SHALL have port rsp_ready  in  1  result consumed when rsp_valid&rsp_ready.
REQ-011 SHALL have port rsp_data  out  4*SIZE  accumulator value read back.
REQ-012 SHALL have ports shift_in, shift_out, mul_and_acc  out  1 each  strobes to the perceptron.
REQ-013 SHALL have port data_in  out  1  serial operand bit to the perceptron.
REQ-014 SHALL have port pe_data_out  in  1  registered serial result bit from the perceptron.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, MAC, RDSH, RDLAST, RSP.
REQ-016 SHALL drive cmd_ready high only in IDLE, with cmd_ready = (state==IDLE) combinationally.
REQ-017 SHALL register every strobe and data_in; at most one strobe high in any cycle.
REQ-018 MAC accepted at cycle 0: SHIFT for cycles 1..2*SIZE with shift_in=1, data_in = cmd_a MSB-first then cmd_b MSB-first (operands captured at acceptance); MAC at cycle 2*SIZE+1 with mul_and_acc=1; IDLE at 2*SIZE+2.
REQ-019 FLUSH: identical timing to MAC with data_in=0 for all 2*SIZE bits; commits the pending product and leaves zero pending.
REQ-020 READ accepted at cycle 0: RDSH for cycles 1..4*SIZE with shift_out=1; RDLAST at 4*SIZE+1 with no strobe; RSP from 4*SIZE+2.
REQ-021 SHALL sample pe_data_out in each cycle following a shift_out cycle (4*SIZE samples), shifting into rsp_data MSB-first: rsp_data <= {rsp_data[4*SIZE-2:0], pe_data_out}.
REQ-022 In RSP, rsp_valid=1 and rsp_data SHALL hold stable until rsp_ready; transfer cycle returns to IDLE next cycle.
REQ-023 NOP SHALL be accepted and return to IDLE next cycle with no strobes.
REQ-024 The sequence counter SHALL be ceil(log2(4*SIZE+1)) bits, cleared on each state entry, no wrap within a state.
REQ-025 cmd_valid, cmd_op, cmd_a and cmd_b changes outside IDLE SHALL be ignored.

Reset
REQ-026 nRst low SHALL force state IDLE, counter 0, all strobes 0, data_in 0, rsp_valid 0, rsp_data 0, operand shift register 0, immediately and regardless of clk.
REQ-027 Reset mid-SHIFT or mid-RDSH SHALL abandon the command with no further strobes; the perceptron is reset by the same nRst.

Structure
REQ-028 Package percept_pkg SHALL hold SIZE default, op encodings, and FSM state encodings, shared with the perceptron bench.
REQ-029 Sub-module percept_deser SHALL implement the sample-enable-delayed 4*SIZE-bit capture shift register.

Verification
REQ-030 MAC a=3 b=5; FLUSH; READ -> rsp_data=15; a second READ -> 0 (readback is destructive).
REQ-031 MAC 0xFFFFFFFF,0xFFFFFFFF twice; FLUSH; READ -> rsp_data = 0x1_FFFFFFFC_00000002.
REQ-032 MAC accepted at cycle 0 -> exactly 64 shift_in cycles (1..64), mul_and_acc only at 65, cmd_ready high at 66, and never two strobes in one cycle.
REQ-033 READ with rsp_ready low for 10 cycles after rsp_valid -> rsp_data unchanged, cmd_ready low, zero strobes, and IDLE one cycle after the handshake.
REQ-034 nRst asserted at SHIFT cycle 20, then MAC 2,7; FLUSH; READ -> rsp_data=14.
REQ-035 cmd_op=11 -> accepted, no strobe, cmd_ready high on the next cycle.
